vga_bar_animator: RTL and testbench

Multi-channel animated split-line generator for the VGA demo path. On each new-frame tick it advances a shared phase through a 120-entry waveform cycle and produces one signed split-line offset per channel, each channel phase-shifted by a fixed spacing. The block runs on the system pixel clock with an edge-detected frame tick, and supports sine, triangle, square and zero waveforms, variable speed, direction, and amplitude attenuation. A single waveform lookup is time-multiplexed across channels, and an update strobe is raised when all outputs are coherent.

---
 rtl/vga_bar_animator.sv | 243 ++++++++++++++++++++++++
 tb/tb_vga_bar_animator.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bar_animator.sv
// vga_bar_animator
//
// Animated split-line generator for the VGA demo path. Each accepted
// new-frame tick advances a shared phase around a 120-entry waveform cycle.
// The block then produces one signed split-line offset per channel, with
// each channel phase-shifted by a fixed number of table entries. A single
// waveform shaper is time-multiplexed across the channels.
//
// Parameters:
//   NUM_CH        number of channels (1..8)
//   PHASE_SPACING table entries between successive channel start phases
//   OUT_W         signed output width per channel (>= 9)
//
// Ports:
//   i_Clk           system pixel clock, rising edge
//   i_Rst_L         asynchronous active-low reset
//   i_NewFrameTick  frame tick level; its rising edge starts a sweep
//   i_Enable        1 = ticks accepted
//   i_Step          phase entries advanced per tick (0 = recompute only)
//   i_Reverse       1 = phase decrements
//   i_Mode          00 sine, 01 triangle, 10 square, 11 zero
//   i_AmpShift      arithmetic right shift applied to the waveform value
//   o_SplitLines    packed signed offsets, channel k at [k*OUT_W +: OUT_W]
//   o_Update        one-cycle pulse once every channel has been refreshed
//   o_Busy          high while a sweep is in progress
module vga_bar_animator #(
  parameter int NUM_CH        = 3,
  parameter int PHASE_SPACING = 40,
  parameter int OUT_W         = 9
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_NewFrameTick,
  input  logic                    i_Enable,
  input  logic [2:0]              i_Step,
  input  logic                    i_Reverse,
  input  logic [1:0]              i_Mode,
  input  logic [1:0]              i_AmpShift,
  output logic [NUM_CH*OUT_W-1:0] o_SplitLines,
  output logic                    o_Update,
  output logic                    o_Busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADVANCE,
    S_ADDR,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic                    tick_prev;
  logic                    tick_edge;
  logic [6:0]              base;
  logic [6:0]              next_base;
  logic [6:0]              phase;
  logic [6:0]              phase_next;
  logic [CH_W-1:0]         ch_idx;
  logic                    last_ch;
  logic [1:0]              mode_r;
  logic [1:0]              amp_r;
  logic signed [OUT_W-1:0] ch_val [NUM_CH];
  logic signed [OUT_W-1:0] shaped;

  logic [6:0]              offset_tbl [NUM_CH];

  // Per-channel start offsets are elaboration constants.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign offset_tbl[g] = 7'((g * PHASE_SPACING) % 120);
    assign o_SplitLines[g*OUT_W +: OUT_W] = ch_val[g];
  end

  // Quarter-wave sine table, 31 entries covering 0..90 degrees.
  function automatic logic [7:0] q_rom(input logic [6:0] idx);
    case (idx)
      7'd0:    q_rom = 8'd0;
      7'd1:    q_rom = 8'd10;
      7'd2:    q_rom = 8'd21;
      7'd3:    q_rom = 8'd31;
      7'd4:    q_rom = 8'd42;
      7'd5:    q_rom = 8'd52;
      7'd6:    q_rom = 8'd62;
      7'd7:    q_rom = 8'd72;
      7'd8:    q_rom = 8'd81;
      7'd9:    q_rom = 8'd91;
      7'd10:   q_rom = 8'd100;
      7'd11:   q_rom = 8'd109;
      7'd12:   q_rom = 8'd118;
      7'd13:   q_rom = 8'd126;
      7'd14:   q_rom = 8'd134;
      7'd15:   q_rom = 8'd141;
      7'd16:   q_rom = 8'd149;
      7'd17:   q_rom = 8'd155;
      7'd18:   q_rom = 8'd162;
      7'd19:   q_rom = 8'd168;
      7'd20:   q_rom = 8'd173;
      7'd21:   q_rom = 8'd178;
      7'd22:   q_rom = 8'd183;
      7'd23:   q_rom = 8'd187;
      7'd24:   q_rom = 8'd190;
      7'd25:   q_rom = 8'd193;
      7'd26:   q_rom = 8'd196;
      7'd27:   q_rom = 8'd198;
      7'd28:   q_rom = 8'd199;
      7'd29:   q_rom = 8'd200;
      7'd30:   q_rom = 8'd200;
      default: q_rom = 8'd0;
    endcase
  endfunction

  assign tick_edge = i_NewFrameTick & ~tick_prev;
  assign last_ch   = (ch_idx == CH_W'(NUM_CH - 1));

  // Base phase after this tick. It always stays within 0..119.
  always_comb begin
    logic [7:0] fwd_sum;
    fwd_sum   = {1'b0, base} + {5'b0, i_Step};
    next_base = base;
    if (!i_Reverse) begin
      if (fwd_sum >= 8'd120) next_base = 7'(fwd_sum - 8'd120);
      else                   next_base = fwd_sum[6:0];
    end else begin
      if (base >= {4'b0, i_Step}) next_base = base - {4'b0, i_Step};
      else next_base = 7'(8'd120 + {1'b0, base} - {5'b0, i_Step});
    end
  end

  // Table position for the channel currently being addressed.
  always_comb begin
    logic [7:0] sum;
    sum = {1'b0, base} + {1'b0, offset_tbl[ch_idx]};
    if (sum >= 8'd120) phase_next = 7'(sum - 8'd120);
    else               phase_next = sum[6:0];
  end

  // Waveform shaper: one lookup shared by all channels, fed by the
  // registered phase and the sweep-latched mode and attenuation.
  always_comb begin
    logic [6:0]         q_idx;
    logic               q_neg;
    logic [7:0]         q_val;
    logic [11:0]        six_p;
    logic signed [11:0] sine_val;
    logic signed [11:0] tri_val;
    logic signed [11:0] raw_val;
    logic signed [11:0] shifted;

    q_idx = phase;
    q_neg = 1'b0;
    if (phase <= 7'd30) begin
      q_idx = phase;
    end else if (phase <= 7'd60) begin
      q_idx = 7'd60 - phase;
    end else if (phase <= 7'd90) begin
      q_idx = phase - 7'd60;
      q_neg = 1'b1;
    end else begin
      q_idx = 7'd120 - phase;
      q_neg = 1'b1;
    end
    q_val    = q_rom(q_idx);
    sine_val = q_neg ? -signed'({4'b0, q_val}) : signed'({4'b0, q_val});

    six_p = {5'b0, phase} * 12'd6;
    if (phase <= 7'd30)      tri_val = signed'(six_p);
    else if (phase <= 7'd90) tri_val = 12'sd360 - signed'(six_p);
    else                     tri_val = signed'(six_p) - 12'sd720;

    case (mode_r)
      2'b00:   raw_val = sine_val;
      2'b01:   raw_val = tri_val;
      2'b10:   raw_val = (phase < 7'd60) ? 12'sd200 : -12'sd200;
      default: raw_val = 12'sd0;
    endcase

    // Arithmetic shift floors toward minus infinity (-21 >>> 1 = -11).
    shifted = raw_val >>> amp_r;
    shaped  = OUT_W'(shifted);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= S_IDLE;
    else          state <= next_state;
  end

  // A sweep is one ADVANCE, an ADDR/WRITE pair per channel, then DONE.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (tick_edge && i_Enable) next_state = S_ADVANCE;
      S_ADVANCE: next_state = S_ADDR;
      S_ADDR:    next_state = S_WRITE;
      S_WRITE:   next_state = last_ch ? S_DONE : S_ADDR;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Datapath. Step and direction are consumed by the base update in
  // ADVANCE; mode and attenuation are held for the rest of the sweep.
  // Busy and update are registered from the state, so they trail it by a
  // cycle. This makes update land exactly when the last channel is stable.
  // tick_prev resets high so a tick already high at release is not an edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tick_prev <= 1'b1;
      base      <= '0;
      phase     <= '0;
      ch_idx    <= '0;
      mode_r    <= '0;
      amp_r     <= '0;
      o_Update  <= 1'b0;
      o_Busy    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) ch_val[k] <= '0;
    end else begin
      tick_prev <= i_NewFrameTick;
      o_Busy    <= (state != S_IDLE);
      o_Update  <= (state == S_DONE);
      case (state)
        S_ADVANCE: begin
          base   <= next_base;
          mode_r <= i_Mode;
          amp_r  <= i_AmpShift;
          ch_idx <= '0;
        end
        S_ADDR: begin
          phase <= phase_next;
        end
        S_WRITE: begin
          ch_val[ch_idx] <= shaped;
          if (!last_ch) ch_idx <= ch_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_bar_animator.sv
// tb_vga_bar_animator
//
// Testbench for vga_bar_animator. A behavioural model tracks the frame timeline
// (E0 = accepted tick edge) and computes each channel's expected value with
// plain arithmetic. A compare process checks every DUT output on every
// negative clock edge. Directed scenarios add literal expectations.
module tb_vga_bar_animator;

  localparam int NUM_CH        = 3;
  localparam int PHASE_SPACING = 40;
  localparam int OUT_W         = 9;
  localparam int SWEEP         = 2 * NUM_CH + 2;

  logic                    clk   = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    tick  = 1'b0;
  logic                    en    = 1'b1;
  logic [2:0]              step  = 3'd0;
  logic                    rev   = 1'b0;
  logic [1:0]              mode  = 2'd0;
  logic [1:0]              amp   = 2'd0;
  logic [NUM_CH*OUT_W-1:0] split_lines;
  logic                    update;
  logic                    busy;

  int vectors     = 0;
  int miscompares = 0;
  int upd_count   = 0;

  vga_bar_animator #(
    .NUM_CH(NUM_CH),
    .PHASE_SPACING(PHASE_SPACING),
    .OUT_W(OUT_W)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_NewFrameTick(tick),
    .i_Enable(en),
    .i_Step(step),
    .i_Reverse(rev),
    .i_Mode(mode),
    .i_AmpShift(amp),
    .o_SplitLines(split_lines),
    .o_Update(update),
    .o_Busy(busy)
  );

  always #5 clk = ~clk;

  int qtab [31] = '{0, 10, 21, 31, 42, 52, 62, 72, 81, 91, 100, 109, 118, 126,
                    134, 141, 149, 155, 162, 168, 173, 178, 183, 187, 190,
                    193, 196, 198, 199, 200, 200};

  function automatic int wave_value(input int md, input int p, input int sh);
    int v;
    v = 0;
    case (md)
      0: begin
        if (p <= 30)      v = qtab[p];
        else if (p <= 60) v = qtab[60 - p];
        else if (p <= 90) v = -qtab[p - 60];
        else              v = -qtab[120 - p];
      end
      1: begin
        if (p <= 30)      v = 6 * p;
        else if (p <= 90) v = 360 - 6 * p;
        else              v = 6 * p - 720;
      end
      2: v = (p < 60) ? 200 : -200;
      default: v = 0;
    endcase
    return v >>> sh;
  endfunction

  // Model state: m_rel counts edges since the accepted tick (-1 = idle).
  int m_base;
  int m_rel;
  int m_mode;
  int m_sh;
  int m_rb;
  bit m_prev;
  bit m_edge;
  bit m_idle;
  int m_new [NUM_CH];
  int m_ch  [NUM_CH];
  bit exp_update;
  bit exp_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_base     = 0;
      m_rel      = -1;
      m_prev     = 1'b1;
      exp_update = 1'b0;
      exp_busy   = 1'b0;
      for (int k = 0; k < NUM_CH; k++) m_ch[k] = 0;
    end else begin
      m_rb       = m_rel;
      m_edge     = tick && !m_prev;
      m_prev     = tick;
      m_idle     = (m_rb < 0) || (m_rb >= SWEEP);
      exp_busy   = (m_rb >= 0) && (m_rb <= SWEEP - 1);
      exp_update = (m_rb == SWEEP - 1);
      if (m_idle && m_edge && en)         m_rel = 0;
      else if (m_rb >= 0 && m_rb < SWEEP) m_rel = m_rb + 1;
      else                                m_rel = -1;
      if (m_rel == 1) begin
        m_mode = int'(mode);
        m_sh   = int'(amp);
        if (rev) m_base = (m_base - int'(step) + 120) % 120;
        else     m_base = (m_base + int'(step)) % 120;
        for (int k = 0; k < NUM_CH; k++)
          m_new[k] = wave_value(m_mode,
                                (m_base + (k * PHASE_SPACING) % 120) % 120, m_sh);
      end
      for (int k = 0; k < NUM_CH; k++)
        if (m_rel == 3 + 2 * k) m_ch[k] = m_new[k];
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  logic [NUM_CH*OUT_W-1:0] exp_lines;
  always @(negedge clk) begin
    int v;
    for (int k = 0; k < NUM_CH; k++) begin
      v = m_ch[k];
      exp_lines[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
    vectors++;
    if (split_lines !== exp_lines || update !== exp_update || busy !== exp_busy) begin
      miscompares++;
      $display("[TB] FAIL cycle_check t=%0t lines=%h req=%h upd=%b req=%b busy=%b req=%b",
               $time, split_lines, exp_lines, update, exp_update, busy, exp_busy);
    end
  end

  always @(negedge clk) if (update === 1'b1) upd_count++;

  function automatic int ch_out(input int k);
    logic signed [OUT_W-1:0] s;
    s = split_lines[k*OUT_W +: OUT_W];
    return int'(s);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] st, input logic rv,
                               input logic [1:0] md, input logic [1:0] sh);
    @(negedge clk);
    step = st;
    rev  = rv;
    mode = md;
    amp  = sh;
  endtask

  task automatic pulseTick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (SWEEP + 2) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ch0", ch_out(0), 0);
    checkOutput("reset_ch2", ch_out(2), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_update", int'(update), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single forward sine tick.
    applyStimulus(3'd1, 1'b0, 2'd0, 2'd0);
    upd_count = 0;
    pulseTick();
    checkOutput("sine1_ch0", ch_out(0), 10);
    checkOutput("sine1_ch1", ch_out(1), 168);
    checkOutput("sine1_ch2", ch_out(2), -178);
    checkOutput("sine1_updates", upd_count, 1);

    // Step 7 from 0: wraps 119 -> 6 on the 18th tick.
    doReset();
    applyStimulus(3'd7, 1'b0, 2'd0, 2'd0);
    repeat (17) pulseTick();
    checkOutput("base119_ch0", ch_out(0), -10);
    checkOutput("base119_ch1", ch_out(1), 178);
    pulseTick();
    checkOutput("base6_ch0", ch_out(0), 62);
    checkOutput("base6_ch2", ch_out(2), -196);

    // Reverse back to 0, then below 0.
    applyStimulus(3'd6, 1'b1, 2'd0, 2'd0);
    pulseTick();
    checkOutput("rev_base0_ch0", ch_out(0), 0);
    applyStimulus(3'd1, 1'b1, 2'd0, 2'd0);
    pulseTick();
    checkOutput("rev_base119_ch0", ch_out(0), -10);

    // Triangle at base 30.
    applyStimulus(3'd7, 1'b0, 2'd1, 2'd0);
    repeat (4) pulseTick();
    applyStimulus(3'd3, 1'b0, 2'd1, 2'd0);
    pulseTick();
    checkOutput("tri30_ch0", ch_out(0), 180);
    checkOutput("tri30_ch1", ch_out(1), -60);

    // Square around the half-cycle boundary.
    applyStimulus(3'd7, 1'b0, 2'd2, 2'd0);
    repeat (4) pulseTick();
    applyStimulus(3'd1, 1'b0, 2'd2, 2'd0);
    pulseTick();
    checkOutput("sq59_ch0", ch_out(0), 200);
    checkOutput("sq59_ch1", ch_out(1), -200);
    pulseTick();
    checkOutput("sq60_ch0", ch_out(0), -200);

    // Zero mode.
    applyStimulus(3'd0, 1'b0, 2'd3, 2'd0);
    pulseTick();
    checkOutput("zero_ch0", ch_out(0), 0);
    checkOutput("zero_ch1", ch_out(1), 0);

    // Attenuation floors negative values: base 62 gives -21 >>> 1.
    applyStimulus(3'd2, 1'b0, 2'd0, 2'd1);
    pulseTick();
    checkOutput("amp_ch0", ch_out(0), -11);
    checkOutput("amp_ch1", ch_out(1), -81);
    checkOutput("amp_ch2", ch_out(2), 91);

    // A tick held high for 100 cycles produces exactly one sweep.
    upd_count = 0;
    @(negedge clk);
    tick = 1'b1;
    repeat (100) @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("held_updates", upd_count, 1);

    // A second edge while busy is dropped.
    upd_count = 0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (SWEEP + 4) @(negedge clk);
    checkOutput("busy_drop_updates", upd_count, 1);

    // Disabled: ticks are ignored.
    upd_count = 0;
    en = 1'b0;
    pulseTick();
    checkOutput("disabled_updates", upd_count, 0);
    checkOutput("disabled_ch0", ch_out(0), -36 >>> 1 == -18 ? wave_value(0, 66, 1) : 0);
    en = 1'b1;

    // Step 0 after a mode change recomputes at the same base (66).
    applyStimulus(3'd0, 1'b0, 2'd1, 2'd0);
    upd_count = 0;
    pulseTick();
    checkOutput("step0_ch0", ch_out(0), -36);
    checkOutput("step0_updates", upd_count, 1);

    // Reset between E4 and E5 with the tick still high at release.
    applyStimulus(3'd1, 1'b0, 2'd0, 2'd0);
    upd_count = 0;
    @(negedge clk);
    tick = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("midsweep_ch0", ch_out(0), -72);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_ch0", ch_out(0), 0);
    checkOutput("abort_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("abort_updates", upd_count, 0);
    checkOutput("abort_busy_after", int'(busy), 0);
    tick = 1'b0;
    pulseTick();
    checkOutput("post_reset_ch0", ch_out(0), 10);
    checkOutput("post_reset_updates", upd_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
